// File: rtl/alu_operand_regfile.sv
// rtl/alu_operand_regfile.sv - operand register file and micro-op sequencer around the datapath ALU
module alu_operand_regfile #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int ALU_LAT  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_srca,
  input  logic [ADDR_W-1:0] req_srcb,
  input  logic [ADDR_W-1:0] req_dst,
  input  logic              req_we,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] A_bus,
  output logic [DATA_W-1:0] B_bus,
  output logic [3:0]        operation,
  output logic              enable,
  input  logic [DATA_W-1:0] C_bus,
  input  logic              Z_flag,
  output logic              done,
  output logic              z_out,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;

  state_t            state;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] dst_q;
  logic              we_q;
  logic              in_idle;

  // Loads win over micro-ops whenever both are offered in IDLE.
  assign in_idle   = (state == S_IDLE);
  assign ld_ready  = in_idle && ld_valid;
  assign req_ready = in_idle && !ld_valid;
  assign rd_data   = regs[rd_addr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      A_bus     <= '0;
      B_bus     <= '0;
      operation <= '0;
      enable    <= 1'b0;
      done      <= 1'b0;
      z_out     <= 1'b0;
      cnt       <= '0;
      dst_q     <= '0;
      we_q      <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      enable <= 1'b0;
      done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ld_valid) begin
            regs[ld_addr] <= ld_data;
          end else if (req_valid) begin
            A_bus     <= regs[req_srca];
            B_bus     <= regs[req_srcb];
            operation <= req_op;
            dst_q     <= req_dst;
            we_q      <= req_we;
            enable    <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= CNT_W'(ALU_LAT - 1);
          state <= S_WAIT;
        end
        S_WAIT: begin
          // done is registered, so it rises together with the WB state.
          if (cnt == '0) begin
            state <= S_WB;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_WB: begin
          if (we_q) regs[dst_q] <= C_bus;
          z_out <= Z_flag;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_regfile.sv
// tb/tb_alu_operand_regfile.sv - randomized scoreboard bench for alu_operand_regfile
module tb_alu_operand_regfile;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = 3;
  localparam int ALU_LAT  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [3:0]        req_op = '0;
  logic [ADDR_W-1:0] req_srca = '0;
  logic [ADDR_W-1:0] req_srcb = '0;
  logic [ADDR_W-1:0] req_dst = '0;
  logic              req_we = 1'b0;
  logic              ld_valid = 1'b0;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [DATA_W-1:0] ld_data = '0;
  logic [DATA_W-1:0] A_bus;
  logic [DATA_W-1:0] B_bus;
  logic [3:0]        operation;
  logic              enable;
  logic [DATA_W-1:0] C_bus;
  logic              Z_flag;
  logic              done;
  logic              z_out;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] rd_data;

  alu_operand_regfile #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .ALU_LAT(ALU_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_srca(req_srca), .req_srcb(req_srcb), .req_dst(req_dst), .req_we(req_we),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .A_bus(A_bus), .B_bus(B_bus), .operation(operation), .enable(enable),
    .C_bus(C_bus), .Z_flag(Z_flag), .done(done), .z_out(z_out),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] alu_f(input logic [3:0] op,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    case (op)
      4'd0:    return a;
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd5:    return a ^ b;
      default: return b;
    endcase
  endfunction

  // Bench ALU: result only valid on the C bus exactly ALU_LAT cycles after the enable cycle.
  logic [DATA_W-1:0] alu_res = '0;
  int                alu_cnt = 0;
  always @(posedge clk) begin
    if (enable) begin
      alu_res <= alu_f(operation, A_bus, B_bus);
      alu_cnt <= ALU_LAT + 1;
    end else if (alu_cnt != 0) begin
      alu_cnt <= alu_cnt - 1;
    end
  end
  assign C_bus  = (alu_cnt == 1) ? alu_res : ~alu_res;
  assign Z_flag = (alu_cnt == 1) ? (alu_res == '0) : (alu_res != '0);

  typedef struct {
    int                hs;
    logic [3:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [ADDR_W-1:0] dst;
    logic [DATA_W-1:0] dst_val;
    logic              z;
  } exp_t;

  exp_t              q[$];
  logic [DATA_W-1:0] model [NUM_REGS];
  int                next_free_edge = 0;
  bit                stim_done = 0;
  bit                mon_done = 0;

  // Resolve what the edge just taken did to the reference model.
  task automatic tick();
    int   e;
    exp_t x;
    @(posedge clk);
    #1;
    e = cyc;
    if (!rst_n) begin
      q.delete();
      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
      next_free_edge = 0;
    end else if (e >= next_free_edge) begin
      if (ld_valid) begin
        model[ld_addr] = ld_data;
        ld_valid = 1'b0;
      end else if (req_valid) begin
        x.hs      = e;
        x.op      = req_op;
        x.a       = model[req_srca];
        x.b       = model[req_srcb];
        x.dst     = req_dst;
        x.z       = (alu_f(req_op, x.a, x.b) == '0);
        if (req_we) model[req_dst] = alu_f(req_op, x.a, x.b);
        x.dst_val = model[req_dst];
        q.push_back(x);
        next_free_edge = e + ALU_LAT + 3;
        req_valid = 1'b0;
      end
    end
  endtask

  task automatic set_req(input logic [3:0] op, input int sa, input int sb, input int d, input logic we);
    req_valid = 1'b1;
    req_op    = op;
    req_srca  = ADDR_W'(sa);
    req_srcb  = ADDR_W'(sb);
    req_dst   = ADDR_W'(d);
    req_we    = we;
  endtask

  task automatic set_ld(input int a, input logic [DATA_W-1:0] d);
    ld_valid = 1'b1;
    ld_addr  = ADDR_W'(a);
    ld_data  = d;
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && (ld_valid || req_valid); k++) tick();
    if (ld_valid || req_valid) begin
      chk("handshake_bound", 32'(ld_valid || req_valid), 32'd0);
      ld_valid  = 1'b0;
      req_valid = 1'b0;
    end
  endtask

  task automatic do_load(input int a, input logic [DATA_W-1:0] d);
    set_ld(a, d);
    drain();
  endtask

  task automatic do_req(input logic [3:0] op, input int sa, input int sb, input int d, input logic we);
    set_req(op, sa, sb, d, we);
    drain();
  endtask

  // Monitor: compares handshake, pulse timing and writeback against the scoreboard.
  logic [DATA_W-1:0] rd_exp = '0;
  bit                chk_rd = 0;
  logic              exp_z = 1'b0;
  initial begin
    bit exp_idle, exp_en, exp_dn;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_z  = 1'b0;
        chk_rd = 0;
      end else begin
        if (chk_rd) begin
          chk("writeback_reg", rd_data, rd_exp);
          chk_rd = 0;
        end
        exp_idle = (cyc + 1 >= next_free_edge);
        chk("req_ready", req_ready, exp_idle && !ld_valid);
        chk("ld_ready", ld_ready, exp_idle && ld_valid);
        exp_en = (q.size() > 0) && (cyc == q[0].hs);
        exp_dn = (q.size() > 0) && (cyc == q[0].hs + 1 + ALU_LAT);
        chk("enable", enable, exp_en);
        chk("done", done, exp_dn);
        chk("z_out", z_out, exp_z);
        if (q.size() > 0 && cyc >= q[0].hs) begin
          chk("A_bus", A_bus, q[0].a);
          chk("B_bus", B_bus, q[0].b);
          chk("operation", operation, q[0].op);
        end
        if (exp_dn) begin
          rd_addr = q[0].dst;
          rd_exp  = q[0].dst_val;
          chk_rd  = 1;
          exp_z   = q[0].z;
          void'(q.pop_front());
        end
        if (stim_done && q.size() == 0 && !chk_rd) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            rd_addr = ADDR_W'(i);
            #1;
            chk($sformatf("final_reg%0d", i), rd_data, model[i]);
          end
          mon_done = 1;
          break;
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_A_bus", A_bus, 32'd0);
    chk("rst_B_bus", B_bus, 32'd0);
    chk("rst_operation", operation, 32'd0);
    chk("rst_enable", enable, 32'd0);
    chk("rst_done", done, 32'd0);

    do_load(1, 16'h0010);
    do_load(2, 16'h0003);
    do_req(4'd1, 1, 2, 3, 1'b1);
    do_load(4, 16'h00AA);
    do_load(5, 16'h00AA);
    do_req(4'd2, 4, 5, 4, 1'b0);
    // Back-to-back: second op reads the first op's writeback.
    do_req(4'd1, 3, 3, 6, 1'b1);
    do_req(4'd1, 6, 1, 7, 1'b1);
    // Load and request offered together in IDLE.
    set_ld(0, 16'h1234);
    set_req(4'd5, 0, 7, 0, 1'b1);
    drain();
    // Load offered while the sequencer is busy.
    set_req(4'd3, 7, 6, 2, 1'b1);
    tick();
    set_ld(5, 16'h0F0F);
    drain();

    for (int n = 0; n < 400; n++) begin
      if (!ld_valid && $urandom_range(0, 3) == 0)
        set_ld($urandom_range(0, NUM_REGS - 1), DATA_W'($urandom_range(0, 3)));
      if (!req_valid && $urandom_range(0, 2) == 0)
        set_req(4'($urandom_range(0, 7)), $urandom_range(0, NUM_REGS - 1),
                $urandom_range(0, NUM_REGS - 1), $urandom_range(0, NUM_REGS - 1),
                1'($urandom_range(0, 1)));
      tick();
    end
    drain();
    for (int k = 0; k < 20 && cyc < next_free_edge; k++) tick();

    // Reset while the op sits in WAIT: no writeback, no done.
    do_load(6, 16'h0055);
    do_req(4'd0, 6, 6, 6, 1'b1);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < ALU_LAT + 4; k++) tick();

    do_load(1, 16'h0007);
    do_req(4'd2, 1, 1, 2, 1'b1);
    for (int k = 0; k < ALU_LAT + 6; k++) tick();
    stim_done = 1;

    for (int k = 0; k < 2000 && !mon_done; k++) @(posedge clk);
    if (!mon_done) chk("monitor_finished", 32'(mon_done), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
